// File: rtl/mem_pkg.sv
// Shared memory-side definitions: bus widths, address/data types and the copier FSM state.
package mem_pkg;

  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 8;

  typedef logic [MEM_ADDR_W-1:0] mem_addr_t;
  typedef logic [MEM_DATA_W-1:0] mem_data_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_WAIT = 3'd2,
    WR      = 3'd3,
    DONE    = 3'd4
  } copier_state_t;

endpackage

// File: rtl/mem_copier.sv
// Block copy engine: reads LEN bytes from SRC and writes them forward to DST, one byte per 3 cycles.
// Define MEM_COPIER_CHECKSUM_EN to add a running byte-sum output of everything read.
module mem_copier
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_to,
  input  logic [DATA_W-1:0] mem_from
`ifdef MEM_COPIER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  copier_state_t     state;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] count;
  logic [ADDR_W-1:0] offset;
  logic [DATA_W-1:0] buffer;

  // The byte buffer is itself the write-data register, so mem_to is stable through WR.
  assign mem_to = buffer;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      count       <= '0;
      offset      <= '0;
      buffer      <= '0;
    end else begin
      done      <= 1'b0;
      mem_write <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            src_q  <= src;
            dst_q  <= dst;
            count  <= len;
            offset <= '0;
            busy   <= 1'b1;
            if (len != '0) begin
              mem_address <= src;
              state       <= RD_ADDR;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        RD_ADDR: state <= RD_WAIT;
        RD_WAIT: begin
          // Capture on the closing edge so a registered-read memory has had a full cycle.
          buffer      <= mem_from;
          mem_address <= dst_q + offset;
          mem_write   <= 1'b1;
          state       <= WR;
        end
        WR: begin
          offset <= offset + 1'b1;
          count  <= count - 1'b1;
          if (count == ADDR_W'(1)) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            mem_address <= src_q + offset + 1'b1;
            state       <= RD_ADDR;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_COPIER_CHECKSUM_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      checksum <= '0;
    end else if (state == IDLE && start) begin
      checksum <= '0;
    end else if (state == RD_WAIT) begin
      checksum <= checksum + mem_from;
    end
  end
`endif

endmodule

// File: tb/tb_mem_copier.sv
// Directed bench for mem_copier against a 256-byte registered-read memory model.
module tb_mem_copier;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] src, dst, len;
  logic       busy, done, mem_write;
  logic [7:0] mem_address, mem_to, mem_from;
`ifdef MEM_COPIER_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  mem_copier dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .src        (src),
    .dst        (dst),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .mem_write  (mem_write),
    .mem_address(mem_address),
    .mem_to     (mem_to),
    .mem_from   (mem_from)
`ifdef MEM_COPIER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clock = ~clock;

  // Memory model with a backdoor write port for preloading.
  logic [7:0] mem [256];
  logic       tb_we = 1'b0;
  logic [7:0] tb_addr = '0;
  logic [7:0] tb_data = '0;

  always @(posedge clock) begin
    if (mem_write) mem[mem_address] <= mem_to;
    else if (tb_we) mem[tb_addr] <= tb_data;
    mem_from <= mem[mem_address];
  end

  // Activity monitor.
  int         busy_cnt = 0, done_cnt = 0, wr_cnt = 0, rd_n = 0;
  logic [7:0] rd_log [64];
  bit         prev_rd = 0;

  always @(negedge clock) begin
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (mem_write) wr_cnt++;
    if (busy && !mem_write && !done) begin
      if (!prev_rd) begin
        rd_log[rd_n % 64] = mem_address;
        rd_n++;
      end
      prev_rd = 1;
    end else begin
      prev_rd = 0;
    end
  end

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    tb_addr = a;
    tb_data = d;
    tb_we   = 1'b1;
    @(posedge clock);
    #1 tb_we = 1'b0;
  endtask

  int         d_busy, d_done, d_wr;
  logic       done_now, got_done;
  logic [7:0] cs_at_done;

  task automatic pulse_start(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
    @(posedge clock);
    #1;
    src = s; dst = d; len = l; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    done_now = done;
  endtask

  task automatic wait_done(input string tag);
    got_done = 1'b0;
    cs_at_done = '0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clock);
      if (done) begin
        got_done = 1'b1;
`ifdef MEM_COPIER_CHECKSUM_EN
        cs_at_done = checksum;
`endif
        break;
      end
    end
    check({tag, "_done_seen"}, got_done, 1);
  endtask

  task automatic run_copy(input string tag, input logic [7:0] s, input logic [7:0] d,
                          input logic [7:0] l);
    int b0, dn0, w0;
    b0 = busy_cnt; dn0 = done_cnt; w0 = wr_cnt;
    pulse_start(s, d, l);
    wait_done(tag);
    repeat (3) @(negedge clock);
    #1;
    d_busy = busy_cnt - b0;
    d_done = done_cnt - dn0;
    d_wr   = wr_cnt - w0;
  endtask

  initial begin
    int r0;
    reset = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr", mem_write, 0);
    check("rst_addr", mem_address, 0);
    check("rst_to", mem_to, 0);
    @(negedge clock) reset = 1'b0;
    for (int i = 0; i < 256; i++) poke(i[7:0], 8'h00);

    // Scenario 1: 16-byte copy 0x80 -> 0x20.
    for (int i = 0; i < 16; i++) poke(8'h80 + i[7:0], i[7:0]);
    run_copy("t1", 8'h80, 8'h20, 8'd16);
    check("t1_busy_cycles", d_busy, 49);
    check("t1_done_pulses", d_done, 1);
    check("t1_writes", d_wr, 16);
    check("t1_done_latency", done_now, 0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t1_dst_%0h", 8'h20 + i), mem[8'h20 + i[7:0]], i);
      check($sformatf("t1_src_%0h", 8'h80 + i), mem[8'h80 + i[7:0]], i);
    end
`ifdef MEM_COPIER_CHECKSUM_EN
    check("t6_cs_at_done", cs_at_done, 8'h78);
    repeat (5) @(negedge clock);
    check("t6_cs_held", checksum, 8'h78);
`endif

    // Scenario 2: zero-length copy.
    run_copy("t2", 8'h80, 8'h00, 8'd0);
    check("t2_done_next_cycle", done_now, 1);
    check("t2_done_pulses", d_done, 1);
    check("t2_no_writes", d_wr, 0);
    check("t2_busy_cycles", d_busy, 1);
    check("t2_mem_unchanged", mem[8'h00], 8'h00);

    // Scenario 4: reset right after the fifth byte has been written.
    for (int i = 0; i < 16; i++) poke(8'h80 + i[7:0], 8'h10 + i[7:0]);
    pulse_start(8'h80, 8'h20, 8'd16);
    r0 = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (mem_write) r0++;
      if (r0 == 5) break;
    end
    check("t4_reached_byte5", r0, 5);
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check("t4_async_busy", busy, 0);
    check("t4_async_wr", mem_write, 0);
    check("t4_async_addr", mem_address, 0);
    check("t4_async_to", mem_to, 0);
    check("t4_async_done", done, 0);
    @(negedge clock) reset = 1'b0;
    check("t4_mem_24", mem[8'h24], 8'h14);
    check("t4_mem_20", mem[8'h20], 8'h10);
    check("t4_mem_25", mem[8'h25], 8'h05);
    run_copy("t4b", 8'h80, 8'h60, 8'd2);
    check("t4b_done_pulses", d_done, 1);
    check("t4b_mem_60", mem[8'h60], 8'h10);
    check("t4b_mem_61", mem[8'h61], 8'h11);

    // Scenario 3: address wrap with overlapping destination.
    poke(8'hFE, 8'hAA); poke(8'hFF, 8'hBB); poke(8'h00, 8'hCC); poke(8'h01, 8'hDD);
    r0 = rd_n;
    run_copy("t3", 8'hFE, 8'h01, 8'd4);
    check("t3_reads", rd_n - r0, 4);
    check("t3_rd0", rd_log[(r0 + 0) % 64], 8'hFE);
    check("t3_rd1", rd_log[(r0 + 1) % 64], 8'hFF);
    check("t3_rd2", rd_log[(r0 + 2) % 64], 8'h00);
    check("t3_rd3", rd_log[(r0 + 3) % 64], 8'h01);
    check("t3_mem_01", mem[8'h01], 8'hAA);
    check("t3_mem_02", mem[8'h02], 8'hBB);
    check("t3_mem_03", mem[8'h03], 8'hCC);
    check("t3_mem_04", mem[8'h04], 8'hAA);

    // Scenario 5: start while busy must be ignored.
    for (int i = 0; i < 4; i++) poke(8'h50 + i[7:0], 8'h5A);
    r0 = done_cnt;
    pulse_start(8'h80, 8'h30, 8'd4);
    repeat (3) @(posedge clock);
    #1;
    dst = 8'h50; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    wait_done("t5");
    repeat (20) @(negedge clock);
    check("t5_done_pulses", done_cnt - r0, 1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t5_dst_%0h", 8'h30 + i), mem[8'h30 + i[7:0]], 8'h10 + i[7:0]);
      check($sformatf("t5_alt_%0h", 8'h50 + i), mem[8'h50 + i[7:0]], 8'h5A);
    end
    check("t5_idle_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_copier.md
Name: mem_copier

Overview:
- Bus-master engine that drives the 8-bit synchronous memory's write/address/data port from the initiator side.
- Copies a block of LEN bytes from SRC to DST: one read, then one write, per byte.
- Sits between the control logic (or the testbench) and the mem instance; while busy it owns the memory port.
- Used for program loading, stack moves and memory-to-memory transfers.

Parameters:
- ADDR_W, 8, memory address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 8, memory data width.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a copy; sampled only in IDLE.
- src  input  ADDR_W  source base address; latched on accepted start.
- dst  input  ADDR_W  destination base address; latched on accepted start.
- len  input  ADDR_W  byte count; latched on accepted start; 0 = no transfer.
- busy  output  1  high from the cycle after start is accepted until DONE completes.
- done  output  1  one-cycle pulse when the copy finishes.
- mem_write  output  1  write enable to memory.
- mem_address  output  ADDR_W  memory address.
- mem_to  output  DATA_W  write data to memory.
- mem_from  input  DATA_W  read data from memory.

Behaviour:
- Reset (async, any state): FSM to IDLE.
  - busy=0, done=0, mem_write=0, mem_address=0, mem_to=0.
  - Internal count, offset and byte buffer cleared.
  - A transfer interrupted by reset is abandoned; partially written bytes remain in memory.
- States: IDLE, RD_ADDR, RD_WAIT, WR, DONE.
- IDLE:
  - mem_write=0.
  - start=1 latches src, dst and len, and clears the offset.
  - len!=0 goes to RD_ADDR; len==0 goes directly to DONE with no memory access.
- RD_ADDR:
  - mem_address = src+offset (mod 2^ADDR_W), mem_write=0.
  - Always goes to RD_WAIT.
- RD_WAIT:
  - Holds the same address, mem_write=0.
  - Captures mem_from into the buffer at the closing edge; this tolerates a registered-read memory.
  - Goes to WR.
- WR:
  - mem_address = dst+offset, mem_to = buffer, mem_write=1 for exactly this one cycle.
  - Offset increments and the count decrements.
  - Goes to DONE when count reaches 0, else to RD_ADDR.
- DONE: done=1 for one cycle, busy=0 next cycle, then back to IDLE.
- Throughput: 3 cycles per byte, plus 1 cycle for DONE, plus 1 cycle of start acceptance.
- mem_write must never be high outside WR.
- mem_address and mem_to are registered outputs, so the memory sees them stable across its sampling edge.
- start while busy is ignored; it is not queued.
- start held high through DONE starts a new copy on the cycle IDLE is re-entered.
- Address wrap:
  - src+offset and dst+offset wrap (e.g. src=0xFE, len=4 reads 0xFE, 0xFF, 0x00, 0x01).
  - len=255 is the maximum.
- Overlap:
  - The copy is strictly forward, byte-by-byte.
  - With dst in (src, src+len), source bytes are overwritten before they are read; this is the defined behaviour, not an error.
  - dst==src rewrites the same values.

Optional Feature:
- Macro: MEM_COPIER_CHECKSUM_EN.
- Defined:
  - Adds output port checksum (DATA_W), the running modulo-2^DATA_W sum of every byte captured in RD_WAIT.
  - Cleared on reset and on each accepted start.
  - Valid and stable from the done pulse until the next accepted start.
- Undefined: the port and its adder do not exist; all other behaviour is identical.

Decomposition:
- Shared package mem_pkg holds:
  - ADDR_W/DATA_W defaults (8), shared with mem.
  - Enumerated state typedef for the copier FSM.
  - Address and data typedefs.
- No sub-module: the FSM, counter and buffer live in one module. Adding a separate sub-module gains nothing.

Test Plan:
1. Preload 0x80..0x8F with 0x00..0x0F; start src=0x80 dst=0x20 len=16. Expect:
   - busy for 49 cycles, then a single done pulse.
   - 0x20..0x2F read back 0x00..0x0F.
   - 0x80..0x8F unchanged.
2. len=0, start. Expect done on the cycle after acceptance, mem_write never high, memory unchanged.
3. Wrap: src=0xFE dst=0x01 len=4, src contents AA BB CC DD. Expect:
   - Reads at FE, FF, 00, 01.
   - Address 0x01 read (already holding AA from the first write) before it is rewritten.
   - Final 0x01..0x04 = AA BB CC AA.
4. Assert reset mid-copy (src=0x80 dst=0x20 len=16, reset during byte 5 WR). Expect:
   - All outputs 0 immediately, asynchronously.
   - 0x20..0x24 written, 0x25.. untouched.
   - Next start works normally.
5. Pulse start again while busy with a different dst. Expect it ignored: the destination stays at the original dst and there is exactly one done pulse.
6. With MEM_COPIER_CHECKSUM_EN, scenario 1. Expect checksum = 0x78 at done, held stable until the next start.
